// File: rtl/vgroup_issue_seq.sv
// Vector register-group issue sequencer: expands one RVV instruction into 1..8
// per-register micro-ops over its LMUL group, each with a vl/SEW-derived byte mask.
module vgroup_issue_seq #(
  parameter int REG_AW   = 5,
  parameter int OP_W     = 4,
  parameter int SCALAR_W = 32,
  parameter int VL_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     in_valu_op,
  input  logic [REG_AW-1:0]   in_raA,
  input  logic [REG_AW-1:0]   in_raB,
  input  logic [REG_AW-1:0]   in_wa,
  input  logic [SCALAR_W-1:0] in_scalar,
  input  logic [2:0]          in_sew,
  input  logic [2:0]          in_lmul,
  input  logic [VL_W-1:0]     in_vl,
  output logic                uop_valid,
  input  logic                uop_ready,
  output logic [OP_W-1:0]     uop_valu_op,
  output logic [REG_AW-1:0]   uop_raA,
  output logic [REG_AW-1:0]   uop_raB,
  output logic [REG_AW-1:0]   uop_wa,
  output logic [SCALAR_W-1:0] uop_scalar,
  output logic [2:0]          uop_sew,
  output logic [2:0]          uop_idx,
  output logic [7:0]          uop_byte_en,
  output logic                uop_last,
  output logic                illegal
);

  typedef enum logic {IDLE, ISSUE} state_t;

  typedef struct packed {
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic [REG_AW-1:0] wa;
    logic [2:0]        g_m1;
    logic [3:0]        epr;
    logic [6:0]        vl_eff;
  } ctx_t;

  state_t state;
  ctx_t   ctx;

  logic [3:0]        dec_g;
  logic [3:0]        dec_epr;
  logic [6:0]        dec_vlmax;
  logic [6:0]        dec_vl_eff;
  logic [REG_AW-1:0] dec_amask;
  logic              dec_illegal;
  logic [2:0]        nxt_idx;

  // Active bytes for register idx: clamp(vl_eff - idx*EPR, 0, EPR) elements, scaled by SEW.
  function automatic logic [7:0] calc_be(input logic [6:0] vl_eff, input logic [2:0] idx,
                                         input logic [3:0] epr, input logic [2:0] sew);
    logic [6:0] base;
    logic [6:0] rem;
    logic [6:0] act;
    logic [6:0] nb;
    logic [8:0] be9;
    base = 7'(idx) * 7'(epr);
    rem  = (vl_eff > base) ? vl_eff - base : 7'd0;
    act  = (rem > 7'(epr)) ? 7'(epr) : rem;
    nb   = act << sew[1:0];
    be9  = (9'd1 << nb[3:0]) - 9'd1;
    return be9[7:0];
  endfunction

  always_comb begin
    dec_g     = 4'd1;
    dec_epr   = 4'd8 >> in_sew[1:0];
    dec_vlmax = 7'(dec_epr);
    case (in_lmul)
      3'b000: begin dec_g = 4'd1; dec_vlmax = 7'(dec_epr);      end
      3'b001: begin dec_g = 4'd2; dec_vlmax = 7'(dec_epr) << 1; end
      3'b010: begin dec_g = 4'd4; dec_vlmax = 7'(dec_epr) << 2; end
      3'b011: begin dec_g = 4'd8; dec_vlmax = 7'(dec_epr) << 3; end
      3'b101: dec_vlmax = 7'(dec_epr) >> 3;
      3'b110: dec_vlmax = 7'(dec_epr) >> 2;
      3'b111: dec_vlmax = 7'(dec_epr) >> 1;
      default: dec_vlmax = 7'd0;
    endcase
    dec_amask   = REG_AW'(dec_g - 4'd1);
    dec_illegal = in_sew[2] || (in_lmul == 3'b100) || (dec_vlmax == 7'd0) ||
                  ((in_raA & dec_amask) != '0) || ((in_raB & dec_amask) != '0) ||
                  ((in_wa & dec_amask) != '0);
    dec_vl_eff  = (in_vl >= VL_W'(dec_vlmax)) ? dec_vlmax : 7'(in_vl);
  end

  assign in_ready = (state == IDLE);
  assign nxt_idx  = uop_idx + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ctx         <= '0;
      uop_valid   <= 1'b0;
      uop_valu_op <= '0;
      uop_raA     <= '0;
      uop_raB     <= '0;
      uop_wa      <= '0;
      uop_scalar  <= '0;
      uop_sew     <= '0;
      uop_idx     <= '0;
      uop_byte_en <= '0;
      uop_last    <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (dec_illegal) begin
              illegal <= 1'b1;
            end else if (dec_vl_eff != 7'd0) begin
              ctx.ra      <= in_raA;
              ctx.rb      <= in_raB;
              ctx.wa      <= in_wa;
              ctx.g_m1    <= 3'(dec_g - 4'd1);
              ctx.epr     <= dec_epr;
              ctx.vl_eff  <= dec_vl_eff;
              uop_valu_op <= in_valu_op;
              uop_scalar  <= in_scalar;
              uop_sew     <= in_sew;
              uop_raA     <= in_raA;
              uop_raB     <= in_raB;
              uop_wa      <= in_wa;
              uop_idx     <= 3'd0;
              uop_byte_en <= calc_be(dec_vl_eff, 3'd0, dec_epr, in_sew);
              uop_last    <= (dec_g == 4'd1);
              uop_valid   <= 1'b1;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (uop_ready) begin
            if (uop_last) begin
              uop_valid <= 1'b0;
              state     <= IDLE;
            end else begin
              // Alignment was checked at accept, so base+idx never wraps.
              uop_idx     <= nxt_idx;
              uop_raA     <= ctx.ra + REG_AW'(nxt_idx);
              uop_raB     <= ctx.rb + REG_AW'(nxt_idx);
              uop_wa      <= ctx.wa + REG_AW'(nxt_idx);
              uop_byte_en <= calc_be(ctx.vl_eff, nxt_idx, ctx.epr, uop_sew);
              uop_last    <= (nxt_idx == ctx.g_m1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vgroup_issue_seq.sv
// Directed vector bench for vgroup_issue_seq: table of instructions plus stall and reset sequences.
module tb_vgroup_issue_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_valu_op = '0;
  logic [4:0]  in_raA = '0, in_raB = '0, in_wa = '0;
  logic [31:0] in_scalar = '0;
  logic [2:0]  in_sew = '0, in_lmul = '0;
  logic [7:0]  in_vl = '0;
  logic        uop_valid;
  logic        uop_ready = 1'b1;
  logic [3:0]  uop_valu_op;
  logic [4:0]  uop_raA, uop_raB, uop_wa;
  logic [31:0] uop_scalar;
  logic [2:0]  uop_sew, uop_idx;
  logic [7:0]  uop_byte_en;
  logic        uop_last;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vgroup_issue_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_valu_op(in_valu_op),
    .in_raA(in_raA), .in_raB(in_raB), .in_wa(in_wa), .in_scalar(in_scalar),
    .in_sew(in_sew), .in_lmul(in_lmul), .in_vl(in_vl),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_valu_op(uop_valu_op),
    .uop_raA(uop_raA), .uop_raB(uop_raB), .uop_wa(uop_wa), .uop_scalar(uop_scalar),
    .uop_sew(uop_sew), .uop_idx(uop_idx), .uop_byte_en(uop_byte_en),
    .uop_last(uop_last), .illegal(illegal)
  );

  typedef struct {
    logic [2:0]       lmul;
    logic [2:0]       sew;
    logic [7:0]       vl;
    logic [4:0]       ra, rb, wa;
    int               n;
    logic             ill;
    logic [7:0][7:0]  be;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] lmul, input logic [2:0] sew, input logic [7:0] vl,
                              input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] wa,
                              input int n, input logic ill,
                              input logic [7:0] b0 = 0, input logic [7:0] b1 = 0,
                              input logic [7:0] b2 = 0, input logic [7:0] b3 = 0,
                              input logic [7:0] b4 = 0, input logic [7:0] b5 = 0,
                              input logic [7:0] b6 = 0, input logic [7:0] b7 = 0);
    vec_t v;
    v.lmul = lmul; v.sew = sew; v.vl = vl; v.ra = ra; v.rb = rb; v.wa = wa;
    v.n = n; v.ill = ill;
    v.be[0] = b0; v.be[1] = b1; v.be[2] = b2; v.be[3] = b3;
    v.be[4] = b4; v.be[5] = b5; v.be[6] = b6; v.be[7] = b7;
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic [3:0] op, input logic [31:0] sc);
    @(negedge clk);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_lmul = v.lmul; in_sew = v.sew; in_vl = v.vl;
    in_raA = v.ra; in_raB = v.rb; in_wa = v.wa; in_valu_op = op; in_scalar = sc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int n;
    logic [3:0]  op;
    logic [31:0] sc;
    op = 4'(k + 3);
    sc = 32'hA5000000 + 32'(k);
    n  = 0;
    drive(v, op, sc);
    chk($sformatf("v%0d_illegal", k), 32'(illegal), 32'(v.ill));
    for (int c = 0; c < 12; c++) begin
      if (uop_valid) begin
        chk($sformatf("v%0d_u%0d_idx", k, n), 32'(uop_idx), 32'(n));
        chk($sformatf("v%0d_u%0d_raA", k, n), 32'(uop_raA), 32'(5'(v.ra + 5'(n))));
        chk($sformatf("v%0d_u%0d_raB", k, n), 32'(uop_raB), 32'(5'(v.rb + 5'(n))));
        chk($sformatf("v%0d_u%0d_wa", k, n), 32'(uop_wa), 32'(5'(v.wa + 5'(n))));
        chk($sformatf("v%0d_u%0d_be", k, n), 32'(uop_byte_en), 32'(n < 8 ? v.be[n] : 8'h00));
        chk($sformatf("v%0d_u%0d_last", k, n), 32'(uop_last), 32'(n == v.n - 1));
        chk($sformatf("v%0d_u%0d_op", k, n), 32'(uop_valu_op), 32'(op));
        chk($sformatf("v%0d_u%0d_scalar", k, n), uop_scalar, sc);
        chk($sformatf("v%0d_u%0d_sew", k, n), 32'(uop_sew), 32'(v.sew));
        chk($sformatf("v%0d_u%0d_in_ready", k, n), 32'(in_ready), 32'd0);
        n++;
      end
      @(negedge clk);
    end
    chk($sformatf("v%0d_uop_count", k), 32'(n), 32'(v.n));
    chk($sformatf("v%0d_in_ready_after", k), 32'(in_ready), 32'd1);
    chk($sformatf("v%0d_illegal_cleared", k), 32'(illegal), 32'd0);
  endtask

  initial begin
    tbl[0]  = mk(3'b000, 3'b010, 8'd2,   5'd3,  5'd5,  5'd7,  1, 1'b0, 8'hFF);
    tbl[1]  = mk(3'b010, 3'b000, 8'd20,  5'd4,  5'd8,  5'd12, 4, 1'b0, 8'hFF, 8'hFF, 8'h0F, 8'h00);
    tbl[2]  = mk(3'b001, 3'b010, 8'd4,   5'd3,  5'd4,  5'd6,  0, 1'b1);
    tbl[3]  = mk(3'b001, 3'b000, 8'd0,   5'd0,  5'd2,  5'd4,  0, 1'b0);
    tbl[4]  = mk(3'b011, 3'b011, 8'd200, 5'd0,  5'd8,  5'd16, 8, 1'b0,
                 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    tbl[5]  = mk(3'b111, 3'b011, 8'd4,   5'd1,  5'd2,  5'd3,  0, 1'b1);
    tbl[6]  = mk(3'b110, 3'b000, 8'd5,   5'd1,  5'd2,  5'd3,  1, 1'b0, 8'h03);
    tbl[7]  = mk(3'b000, 3'b100, 8'd4,   5'd1,  5'd2,  5'd3,  0, 1'b1);
    tbl[8]  = mk(3'b100, 3'b000, 8'd4,   5'd0,  5'd2,  5'd4,  0, 1'b1);
    tbl[9]  = mk(3'b001, 3'b001, 8'd5,   5'd2,  5'd4,  5'd6,  2, 1'b0, 8'hFF, 8'h03);
    tbl[10] = mk(3'b000, 3'b000, 8'd3,   5'd30, 5'd31, 5'd9,  1, 1'b0, 8'h07);

    #2;
    chk("rst_uop_valid", 32'(uop_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_byte_en", 32'(uop_byte_en), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 11; k++) run_vec(tbl[k], k);

    // Backpressure at idx1: fields must hold while uop_ready is low.
    begin
      vec_t s;
      s = mk(3'b001, 3'b011, 8'd2, 5'd2, 5'd4, 5'd6, 2, 1'b0, 8'hFF, 8'hFF);
      uop_ready = 1'b1;
      drive(s, 4'd9, 32'h1234);
      chk("stall_u0_idx", 32'(uop_idx), 32'd0);
      @(negedge clk);
      chk("stall_u1_valid", 32'(uop_valid), 32'd1);
      uop_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk($sformatf("stall_c%0d_valid", c), 32'(uop_valid), 32'd1);
        chk($sformatf("stall_c%0d_idx", c), 32'(uop_idx), 32'd1);
        chk($sformatf("stall_c%0d_wa", c), 32'(uop_wa), 32'd7);
        chk($sformatf("stall_c%0d_be", c), 32'(uop_byte_en), 32'hFF);
        chk($sformatf("stall_c%0d_last", c), 32'(uop_last), 32'd1);
      end
      uop_ready = 1'b1;
      @(negedge clk);
      chk("stall_done_valid", 32'(uop_valid), 32'd0);
      chk("stall_done_in_ready", 32'(in_ready), 32'd1);
    end

    // Reset while idx2 of an LMUL=8 group is presented.
    begin
      vec_t r;
      r = mk(3'b011, 3'b000, 8'd64, 5'd8, 5'd16, 5'd24, 8, 1'b0);
      drive(r, 4'd1, 32'h0);
      @(negedge clk); @(negedge clk);
      chk("rstmid_idx2", 32'(uop_idx), 32'd2);
      chk("rstmid_valid_before", 32'(uop_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstmid_valid", 32'(uop_valid), 32'd0);
      chk("rstmid_in_ready", 32'(in_ready), 32'd1);
      chk("rstmid_idx", 32'(uop_idx), 32'd0);
      chk("rstmid_wa", 32'(uop_wa), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_vec(tbl[0], 20);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
